// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage MIPS32 core: stall arbitration, multi-cycle
// execute sequencing, flush/redirect generation and a saturating stall counter.
module pipe_ctrl #(
  parameter int unsigned LEN_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             ex_mc_start_i,
  input  logic [LEN_W-1:0] ex_mc_len_i,
  input  logic             flush_req_i,
  input  logic [31:0]      flush_pc_i,
  input  logic             perf_clr_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             mc_busy_o,
  output logic             mc_cancel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] HOLD_ALL = 6'b111111;
  localparam logic [5:0] HOLD_EX  = 6'b001111;
  localparam logic [5:0] HOLD_ID  = 6'b000111;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             mc_req;

  // A zero-length start is a no-op; any non-zero length stalls from its first cycle.
  assign mc_req    = (state == IDLE) && ex_mc_start_i && (ex_mc_len_i != '0);
  assign mc_busy_o = (state == RUN);

  always_comb begin
    stall_o = '0;
    if (!rst) begin
      stall_o = '0;
    end else if (flush_req_i) begin
      stall_o = HOLD_ALL;
    end else if (state == FLUSH) begin
      stall_o = '0;
    end else if ((state == RUN) || mc_req || stallreq_ex_i) begin
      stall_o = HOLD_EX;
    end else if (stallreq_id_i) begin
      stall_o = HOLD_ID;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      flush_o     <= 1'b0;
      mc_cancel_o <= 1'b0;
      new_pc_o    <= '0;
    end else if (flush_req_i) begin
      state       <= FLUSH;
      cnt         <= '0;
      flush_o     <= 1'b1;
      mc_cancel_o <= 1'b1;
      new_pc_o    <= flush_pc_i;
    end else begin
      flush_o     <= 1'b0;
      mc_cancel_o <= 1'b0;
      unique case (state)
        IDLE: begin
          // The start cycle is itself the first stall cycle, so RUN covers L-1 more.
          if (mc_req && (ex_mc_len_i > LEN_W'(1))) begin
            state <= RUN;
            cnt   <= ex_mc_len_i - LEN_W'(1);
          end
        end
        RUN: begin
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_o <= '0;
    end else if ((stall_o != '0) && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS32 core. It arbitrates stall requests from the decode stage (load-use) and the execute stage (busy units), and sequences multi-cycle execute operations with an internal cycle counter. It also converts exception/redirect requests into a one-cycle pipeline flush with a new fetch address. It drives the per-stage hold vector consumed by pc_reg and every inter-stage pipeline register.

## Interface
Parameters:
- LEN_W, 6, width of the multi-cycle length field (max length 2^LEN_W-1)
- CNT_W, 16, width of the saturating stall performance counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stallreq_id_i  in  1  decode requests a stall (load-use hazard)
- stallreq_ex_i  in  1  execute unit is busy (open-ended, level)
- ex_mc_start_i  in  1  execute stage starts a fixed-length multi-cycle op this cycle
- ex_mc_len_i  in  LEN_W  total stall cycles for that op
- flush_req_i  in  1  exception/redirect request from mem stage
- flush_pc_i  in  32  target fetch address for the flush
- perf_clr_i  in  1  synchronous clear of stall counter
- stall_o  out  6  hold vector: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb
- flush_o  out  1  clear all pipeline registers, load new_pc_o
- new_pc_o  out  32  redirect address, valid when flush_o=1
- mc_busy_o  out  1  multi-cycle sequencer in RUN
- mc_cancel_o  out  1  abort in-flight multi-cycle op in execute unit
- stall_cnt_o  out  CNT_W  cycles with stall_o != 0, saturating

## Operation
- States: IDLE, RUN, FLUSH. Registers: state, cnt (LEN_W), flush_o, new_pc_o, mc_cancel_o, stall_cnt_o.
- stall_o is combinational from inputs and state, priority highest first:
  - flush_req_i=1 -> 6'b111111 (freeze everything for the request cycle)
  - state=FLUSH -> 6'b000000
  - state=RUN, or ex_mc_start_i=1 with ex_mc_len_i!=0 in IDLE, or stallreq_ex_i=1 -> 6'b001111
  - stallreq_id_i=1 -> 6'b000111
  - else 6'b000000
- IDLE: ex_mc_start_i with len L: L=0 ignored; L=1 stall this cycle only, stay IDLE; L>=2 go RUN, cnt<=L-1.
- RUN: cnt decrements each cycle; cnt=1 -> IDLE next. Total stall cycles for an op = L exactly. ex_mc_start_i ignored in RUN.
- flush_req_i in any state (including RUN and FLUSH): next state FLUSH, new_pc_o<=flush_pc_i, cnt<=0. Flush preempts and discards any RUN sequence.
- FLUSH (one cycle): flush_o=1, mc_cancel_o=1; then IDLE unless flush_req_i is asserted again, which re-enters FLUSH with the new pc.
- mc_busy_o = (state==RUN).
- stall_cnt_o: perf_clr_i -> 0 (priority). Otherwise +1 when stall_o!=0, holding at all-ones.

## Timing
- Reset (rst=0, async): state IDLE, cnt 0, flush_o 0, new_pc_o 0, mc_cancel_o 0, mc_busy_o 0, stall_cnt_o 0. stall_o forced to 0 while rst=0.
- stall_o: zero latency, same cycle as the request.
- flush_o/new_pc_o/mc_cancel_o: registered, asserted exactly one cycle, in the cycle after flush_req_i.
- A multi-cycle op started at cycle C with length L holds stall_o=6'b001111 in cycles C..C+L-1. It is released at C+L.
- stallreq_ex_i together with RUN gives no extension beyond the OR of the two.
- Reset asserted mid-RUN or mid-FLUSH aborts immediately. No pending flush survives reset.

## Test plan
- Reset then idle inputs -> stall_o=0, flush_o=0, new_pc_o=0, stall_cnt_o=0.
- stallreq_id_i high 1 cycle -> stall_o=6'b000111 that cycle, stall_cnt_o=1 afterwards. With stallreq_ex_i also high -> 6'b001111.
- ex_mc_start_i, len=5 at cycle 10 -> stall_o=6'b001111 in cycles 10-14, mc_busy_o=1 in cycles 11-14, stall_o=0 at cycle 15. Repeat with len=1 (single cycle, mc_busy_o stays 0) and len=0 (no stall).
- len=8 started, flush_req_i at 3rd stall cycle with flush_pc_i=32'h0000_0180 -> stall_o=6'h3F that cycle. Next cycle flush_o=1, mc_cancel_o=1, new_pc_o=32'h180, stall_o=0. Then IDLE, mc_busy_o=0.
- flush_req_i on two consecutive cycles (pcs 0x100, 0x200) -> flush_o high two cycles, new_pc_o=0x100 then 0x200.
- Force 70000 stall cycles -> stall_cnt_o saturates at 16'hFFFF. perf_clr_i while stalling -> 0 that edge, then counting resumes.
